// File: rtl/efi_ctrl_hub_pkg.sv
// Shared definitions for the EFI control hub: register map, routing modes,
// divider states and power-on configuration values.
package efi_ctrl_hub_pkg;

  localparam logic [5:0] ADDR_CTRL      = 6'd0;
  localparam logic [5:0] ADDR_TOOTH     = 6'd1;
  localparam logic [5:0] ADDR_MISSING   = 6'd2;
  localparam logic [5:0] ADDR_TIMING    = 6'd3;
  localparam logic [5:0] ADDR_DWELL     = 6'd4;
  localparam logic [5:0] ADDR_REV_LIMIT = 6'd5;
  localparam logic [5:0] ADDR_COMMIT    = 6'd6;
  localparam logic [5:0] ADDR_IGN_PHASE = 6'd8;
  localparam logic [5:0] ADDR_INJ_PW    = 6'd16;
  localparam logic [5:0] ADDR_STATUS    = 6'd32;
  localparam logic [5:0] ADDR_RPM       = 6'd33;

  typedef enum logic [1:0] {
    MODE_INDEP     = 2'b00,
    MODE_DIST      = 2'b01,
    MODE_WASTED    = 2'b10,
    MODE_INDEP_ALT = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_RUN  = 2'b01,
    DIV_DONE = 2'b10
  } div_state_t;

  typedef struct packed {
    logic [15:0] ctrl;
    logic [15:0] tooth_cnt;
    logic [15:0] teeth_missing;
    logic [15:0] ign_timing;
    logic [15:0] dwell;
    logic [15:0] rev_limit;
  } efi_cfg_t;

  localparam efi_cfg_t CFG_DEFAULT = '{
    ctrl:          16'h0037,
    tooth_cnt:     16'd60,
    teeth_missing: 16'd2,
    ign_timing:    16'd342,
    dwell:         16'd342,
    rev_limit:     16'd0
  };

  localparam logic [15:0] DEF_INJ_PW0 = 16'd2000;

  function automatic logic [15:0] quanta_of(input logic [15:0] tooth_cnt);
    return {tooth_cnt[7:0], 8'h00};
  endfunction

  function automatic logic [15:0] phase_default(input int idx, input int n);
    logic [15:0] q;
    q = quanta_of(CFG_DEFAULT.tooth_cnt);
    return 16'(idx * (int'(q) / n));
  endfunction

  // Quotients above 16 bits, or a zero divisor, pin the RPM at full scale.
  function automatic logic [15:0] rpm_sat(input logic [25:0] quo, input logic div_zero);
    return (div_zero || (quo[25:16] != 10'h000)) ? 16'hFFFF : quo[15:0];
  endfunction

endpackage

// File: rtl/efi_ctrl_hub_if.sv
// Register bus between the SPI slave (master side) and the control hub.
interface efi_ctrl_hub_if;
  logic        reg_wr_en;
  logic [5:0]  reg_addr;
  logic [15:0] reg_wr_data;
  logic [15:0] reg_rd_data;

  modport master (output reg_wr_en, reg_addr, reg_wr_data, input reg_rd_data);
  modport slave  (input reg_wr_en, reg_addr, reg_wr_data, output reg_rd_data);
endinterface

// File: rtl/efi_ctrl_hub_rpm_div.sv
// Sequential restoring divider computing RPM = RPM_CONST / divisor over 26
// iterations, saturating to 0xFFFF; abort drops any division in flight.
module efi_rpm_div
  import efi_ctrl_hub_pkg::*;
#(
  parameter int unsigned RPM_CONST = 64_000_000,
  parameter int unsigned RPM_SUM_W = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [RPM_SUM_W-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          result
);

  localparam int unsigned  ITER      = 26;
  localparam logic [25:0]  DIVIDEND  = 26'(RPM_CONST);
  localparam logic [4:0]   LAST_ITER = 5'(ITER - 1);

  div_state_t           state_r, state_nxt_s;
  logic [RPM_SUM_W-1:0] div_r, rem_r, rem_nxt_s;
  logic [RPM_SUM_W:0]   rem_sh_s, diff_s;
  logic [25:0]          quo_r, quo_nxt_s;
  logic [4:0]           cnt_r;
  logic                 ge_s;
  logic [15:0]          result_r;
  logic                 unused_msb_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= DIV_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      DIV_IDLE: begin
        if (start && !abort) state_nxt_s = DIV_RUN;
        else                 state_nxt_s = DIV_IDLE;
      end
      DIV_RUN: begin
        if (abort)                   state_nxt_s = DIV_IDLE;
        else if (cnt_r == LAST_ITER) state_nxt_s = DIV_DONE;
        else                         state_nxt_s = DIV_RUN;
      end
      DIV_DONE: state_nxt_s = DIV_IDLE;
      default:  state_nxt_s = DIV_IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_r)
      DIV_RUN:  busy = 1'b1;
      DIV_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // One restoring step: quotient bits shift in as dividend bits shift out.
  always_comb begin
    rem_sh_s  = {rem_r, quo_r[25]};
    ge_s      = (rem_sh_s >= {1'b0, div_r});
    diff_s    = rem_sh_s - {1'b0, div_r};
    rem_nxt_s = ge_s ? diff_s[RPM_SUM_W-1:0] : rem_sh_s[RPM_SUM_W-1:0];
    quo_nxt_s = {quo_r[24:0], ge_s};
  end

  assign unused_msb_s = diff_s[RPM_SUM_W];

  // Divider datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r    <= {RPM_SUM_W{1'b0}};
      rem_r    <= {RPM_SUM_W{1'b0}};
      quo_r    <= 26'h0;
      cnt_r    <= 5'd0;
      result_r <= 16'h0000;
    end else if (state_r == DIV_IDLE && start && !abort) begin
      div_r <= divisor;
      rem_r <= {RPM_SUM_W{1'b0}};
      quo_r <= DIVIDEND;
      cnt_r <= 5'd0;
    end else if (state_r == DIV_RUN) begin
      rem_r <= rem_nxt_s;
      quo_r <= quo_nxt_s;
      cnt_r <= cnt_r + 5'd1;
      if (cnt_r == LAST_ITER)
        result_r <= rpm_sat(quo_nxt_s, div_r == {RPM_SUM_W{1'b0}});
    end
  end

  assign result = result_r;

endmodule

// File: rtl/efi_ctrl_hub.sv
// EFI control hub: shadow/active register bank committed at engine-cycle
// boundaries, RPM measurement, rev limiter and ignition/injector routing.
module efi_ctrl_hub
  import efi_ctrl_hub_pkg::*;
#(
  parameter int unsigned NUM_IGN   = 4,
  parameter int unsigned NUM_INJ   = 2,
  parameter int unsigned RPM_CONST = 64_000_000,
  parameter int unsigned RPM_SUM_W = 20,
  parameter int unsigned REV_HYST  = 200
) (
  input  logic                    clk,
  input  logic                    reset,
  efi_ctrl_hub_if.slave           bus,
  input  logic                    synced,
  input  logic                    trigger,
  input  logic                    cycle_start,
  input  logic [31:0]             rpm_sum,
  input  logic [NUM_IGN-1:0]      ign_req,
  input  logic [NUM_INJ-1:0]      inj_req,
  output logic [NUM_IGN-1:0]      ign_out,
  output logic [NUM_INJ-1:0]      inj_out,
  output logic [15:0]             cfg_tooth_cnt,
  output logic [15:0]             cfg_teeth_missing,
  output logic [15:0]             cfg_ign_timing,
  output logic [15:0]             cfg_dwell,
  output logic [15:0]             cfg_quanta_per_rev,
  output logic [16*NUM_IGN-1:0]   cfg_ign_phase,
  output logic [16*NUM_INJ-1:0]   cfg_inj_pw,
  output logic [15:0]             rpm,
  output logic                    rev_cut
);

  localparam logic [7:0]  IGN_MASK     = 8'((1 << NUM_IGN) - 1);
  localparam logic [3:0]  INJ_MASK     = 4'((1 << NUM_INJ) - 1);
  localparam logic [15:0] CTRL_WR_MASK = {2'b00, 2'b11, INJ_MASK, IGN_MASK};

  function automatic logic [NUM_IGN-1:0][15:0] phase_defaults();
    logic [NUM_IGN-1:0][15:0] v;
    for (int i = 0; i < NUM_IGN; i++) v[i] = phase_default(i, NUM_IGN);
    return v;
  endfunction

  function automatic logic [NUM_INJ-1:0][15:0] pw_defaults();
    logic [NUM_INJ-1:0][15:0] v;
    for (int i = 0; i < NUM_INJ; i++) v[i] = (i == 0) ? DEF_INJ_PW0 : 16'h0000;
    return v;
  endfunction

  localparam logic [NUM_IGN-1:0][15:0] PHASE_DEF = phase_defaults();
  localparam logic [NUM_INJ-1:0][15:0] PW_DEF    = pw_defaults();

  efi_cfg_t                 sh_r, act_r;
  logic [NUM_IGN-1:0][15:0] sh_phase_r, act_phase_r;
  logic [NUM_INJ-1:0][15:0] sh_pw_r, act_pw_r;
  logic [15:0]              quanta_r;
  logic                     pending_r, xfer_s, wr_s;
  logic [15:0]              rd_s, rd_r;
  logic [15:0]              rpm_r, rel_s;
  logic                     rev_cut_r, rev_nxt_s;
  logic                     div_busy_s, div_done_s;
  logic [15:0]              div_result_s;
  logic [NUM_IGN-1:0]       e_s, route_s, ign_nxt_s, ign_out_r;
  logic [NUM_INJ-1:0]       inj_nxt_s, inj_out_r;
  mode_t                    mode_s;
  logic                     unused_bits_s;

  assign wr_s   = bus.reg_wr_en;
  assign xfer_s = pending_r & (cycle_start | ~synced);

  // Shadow register writes; the power-on ctrl value is loaded as-is, later writes are masked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_r       <= CFG_DEFAULT;
      sh_phase_r <= PHASE_DEF;
      sh_pw_r    <= PW_DEF;
    end else if (wr_s) begin
      case (bus.reg_addr)
        ADDR_CTRL:      sh_r.ctrl          <= bus.reg_wr_data & CTRL_WR_MASK;
        ADDR_TOOTH:     sh_r.tooth_cnt     <= bus.reg_wr_data;
        ADDR_MISSING:   sh_r.teeth_missing <= bus.reg_wr_data;
        ADDR_TIMING:    sh_r.ign_timing    <= bus.reg_wr_data;
        ADDR_DWELL:     sh_r.dwell         <= bus.reg_wr_data;
        ADDR_REV_LIMIT: sh_r.rev_limit     <= bus.reg_wr_data;
        default:        sh_r               <= sh_r;
      endcase
      for (int i = 0; i < NUM_IGN; i++)
        if (bus.reg_addr == ADDR_IGN_PHASE + 6'(i)) sh_phase_r[i] <= bus.reg_wr_data;
      for (int i = 0; i < NUM_INJ; i++)
        if (bus.reg_addr == ADDR_INJ_PW + 6'(i)) sh_pw_r[i] <= bus.reg_wr_data;
    end
  end

  // Active copy; the transfer sees the shadow value from before any same-cycle write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_r       <= CFG_DEFAULT;
      act_phase_r <= PHASE_DEF;
      act_pw_r    <= PW_DEF;
      quanta_r    <= quanta_of(CFG_DEFAULT.tooth_cnt);
    end else if (xfer_s) begin
      act_r       <= sh_r;
      act_phase_r <= sh_phase_r;
      act_pw_r    <= sh_pw_r;
      quanta_r    <= quanta_of(sh_r.tooth_cnt);
    end
  end

  // Commit pending flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        pending_r <= 1'b0;
    else if (xfer_s)                                  pending_r <= 1'b0;
    else if (wr_s && bus.reg_addr == ADDR_COMMIT)     pending_r <= 1'b1;
  end

  // Read mux over shadow registers and status.
  always_comb begin
    rd_s = 16'h0000;
    case (bus.reg_addr)
      ADDR_CTRL:      rd_s = sh_r.ctrl;
      ADDR_TOOTH:     rd_s = sh_r.tooth_cnt;
      ADDR_MISSING:   rd_s = sh_r.teeth_missing;
      ADDR_TIMING:    rd_s = sh_r.ign_timing;
      ADDR_DWELL:     rd_s = sh_r.dwell;
      ADDR_REV_LIMIT: rd_s = sh_r.rev_limit;
      ADDR_STATUS:    rd_s = {13'h0000, pending_r, rev_cut_r, synced};
      ADDR_RPM:       rd_s = rpm_r;
      default:        rd_s = 16'h0000;
    endcase
    for (int i = 0; i < NUM_IGN; i++)
      rd_s = (bus.reg_addr == ADDR_IGN_PHASE + 6'(i)) ? sh_phase_r[i] : rd_s;
    for (int i = 0; i < NUM_INJ; i++)
      rd_s = (bus.reg_addr == ADDR_INJ_PW + 6'(i)) ? sh_pw_r[i] : rd_s;
  end

  // Registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_r <= 16'h0000;
    else       rd_r <= rd_s;
  end

  efi_rpm_div #(
    .RPM_CONST (RPM_CONST),
    .RPM_SUM_W (RPM_SUM_W)
  ) u_rpm_div (
    .clk     (clk),
    .rst     (reset),
    .start   (trigger & synced),
    .abort   (~synced),
    .divisor (rpm_sum[RPM_SUM_W-1:0]),
    .busy    (div_busy_s),
    .done    (div_done_s),
    .result  (div_result_s)
  );

  // Rev limiter decision for a freshly arrived RPM result.
  always_comb begin
    rel_s     = (act_r.rev_limit > 16'(REV_HYST)) ? act_r.rev_limit - 16'(REV_HYST) : 16'h0000;
    rev_nxt_s = rev_cut_r;
    if (act_r.rev_limit == 16'h0000)         rev_nxt_s = 1'b0;
    else if (div_result_s >= act_r.rev_limit) rev_nxt_s = 1'b1;
    else if (div_result_s < rel_s)            rev_nxt_s = 1'b0;
    else                                      rev_nxt_s = rev_cut_r;
  end

  // RPM result and rev-cut state; losing sync clears both immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpm_r     <= 16'h0000;
      rev_cut_r <= 1'b0;
    end else if (!synced) begin
      rpm_r     <= 16'h0000;
      rev_cut_r <= 1'b0;
    end else if (div_done_s) begin
      rpm_r     <= div_result_s;
      rev_cut_r <= rev_nxt_s;
    end
  end

  assign mode_s = mode_t'(act_r.ctrl[13:12]);
  assign e_s    = ign_req & act_r.ctrl[NUM_IGN-1:0];

  // Ignition routing by mode, then global gating.
  always_comb begin
    route_s = {NUM_IGN{1'b0}};
    case (mode_s)
      MODE_DIST: route_s[0] = |e_s;
      MODE_WASTED: begin
        if ((NUM_IGN % 2) == 0) begin
          for (int i = 0; i < NUM_IGN / 2; i++) route_s[i] = e_s[i] | e_s[i + NUM_IGN / 2];
        end else begin
          route_s = e_s;
        end
      end
      default: route_s = e_s;
    endcase
    if (rev_cut_r || !synced) ign_nxt_s = {NUM_IGN{1'b0}};
    else                      ign_nxt_s = route_s;
    inj_nxt_s = inj_req & act_r.ctrl[8 +: NUM_INJ] & {NUM_INJ{synced & ~rev_cut_r}};
  end

  // Registered channel outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ign_out_r <= {NUM_IGN{1'b0}};
      inj_out_r <= {NUM_INJ{1'b0}};
    end else begin
      ign_out_r <= ign_nxt_s;
      inj_out_r <= inj_nxt_s;
    end
  end

  assign unused_bits_s = ^{rpm_sum, act_r.ctrl, div_busy_s};

  assign bus.reg_rd_data    = rd_r;
  assign ign_out            = ign_out_r;
  assign inj_out            = inj_out_r;
  assign cfg_tooth_cnt      = act_r.tooth_cnt;
  assign cfg_teeth_missing  = act_r.teeth_missing;
  assign cfg_ign_timing     = act_r.ign_timing;
  assign cfg_dwell          = act_r.dwell;
  assign cfg_quanta_per_rev = quanta_r;
  assign cfg_ign_phase      = act_phase_r;
  assign cfg_inj_pw         = act_pw_r;
  assign rpm                = rpm_r;
  assign rev_cut            = rev_cut_r;

endmodule
